// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer
//   Runs serial conversion frames against the 8-channel, 12-bit ADC in
//   front of the signal capture block. adc_sclk is built here from CLOCK_50
//   by cycle counting. Enabled channels are visited round-robin, and each
//   completed frame is handed downstream as a one-cycle sample_valid pulse
//   carrying the channel tag and the data.
//
//   Frame timeline, with H = SCLK_HALF and Q = QUIET_CYCLES:
//     IDLE (1 cycle) -> SETUP (H) -> SHIFT (32H) -> HOLD (H) -> QUIET (Q)
//   A frame therefore repeats every 1 + 34H + Q cycles, and cs_n is low
//   for 34H of them.
//
// Ports
//   CLOCK_50     in   system clock
//   resetN       in   asynchronous active-low reset
//   run          in   1 = keep converting
//   ch_enable    in   channel mask, bit i enables channel i
//   adc_sclk     out  serial clock to the ADC, idles high
//   adc_cs_n     out  chip select, active low
//   adc_din      out  control word to the ADC (MOSI)
//   adc_dout     in   conversion data from the ADC (MISO)
//   sample_valid out  one-cycle pulse per completed frame
//   sample_ch    out  channel echo taken from the frame
//   sample_data  out  conversion result
//   busy         out  high from the cs_n fall through the end of QUIET
//   ch_err       out  sticky channel-mismatch flag
//
// Build option
//   ADC_CH_MISMATCH_CHK_EN : when defined, the echoed channel of each frame
//   is compared against the channel addressed in the previous frame, and
//   any mismatch sets ch_err. When undefined, ch_err is tied low.
module adc_capture_sequencer #(
  parameter int SCLK_HALF    = 2,
  parameter int QUIET_CYCLES = 4,
  parameter int NUM_CH       = 8,
  parameter int DATA_BITS    = 12
) (
  input  logic                 CLOCK_50,
  input  logic                 resetN,
  input  logic                 run,
  input  logic [NUM_CH-1:0]    ch_enable,
  output logic                 adc_sclk,
  output logic                 adc_cs_n,
  output logic                 adc_din,
  input  logic                 adc_dout,
  output logic                 sample_valid,
  output logic [2:0]           sample_ch,
  output logic [DATA_BITS-1:0] sample_data,
  output logic                 busy,
  output logic                 ch_err
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(SCLK_HALF - 1);
  localparam logic [QW-1:0] Q_LAST = QW'(QUIET_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, QUIET} stateT;

  stateT         state;
  logic [HW-1:0] halfCnt;
  logic [QW-1:0] quietCnt;
  logic [3:0]    bitCnt;
  logic [2:0]    curCh;
  logic [15:0]   txShift;
  // The first received bit is a don't-care, so only the 15 useful bits are kept.
  logic [14:0]   rxShift;
  logic [2:0]    nextCh;
  logic [15:0]   ctrlWord;

  // The lowest enabled index strictly above cur, wrapping to the lowest
  // enabled index. The descending scans leave the lowest match in pick.
  function automatic logic [2:0] pickNext(input logic [NUM_CH-1:0] mask,
                                          input logic [2:0] cur);
    logic [2:0] pick;
    pick = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask[i]) pick = 3'(i);
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask[i] && (3'(i) > cur)) pick = 3'(i);
    return pick;
  endfunction

  assign nextCh   = pickNext(ch_enable, curCh);
  assign ctrlWord = {2'b10, nextCh, 11'd0};

  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      halfCnt      <= '0;
      quietCnt     <= '0;
      bitCnt       <= '0;
      curCh        <= 3'd7;
      txShift      <= '0;
      rxShift      <= '0;
      adc_sclk     <= 1'b1;
      adc_cs_n     <= 1'b1;
      adc_din      <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run && (|ch_enable)) begin
            state    <= SETUP;
            curCh    <= nextCh;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b1;
            adc_din  <= ctrlWord[15];
            txShift  <= {ctrlWord[14:0], 1'b0};
            halfCnt  <= '0;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (halfCnt == H_LAST) begin
            // The first sclk fall. din already holds ctrl[15] for bit 0.
            halfCnt  <= '0;
            bitCnt   <= '0;
            adc_sclk <= 1'b0;
            state    <= SHIFT;
          end else begin
            halfCnt <= halfCnt + 1'b1;
          end
        end
        SHIFT: begin
          if (halfCnt == H_LAST) begin
            halfCnt <= '0;
            if (!adc_sclk) begin
              // Rising edge: MISO has been stable through the low phase.
              adc_sclk <= 1'b1;
              rxShift  <= {rxShift[13:0], adc_dout};
            end else if (bitCnt == 4'd15) begin
              state <= HOLD;
            end else begin
              bitCnt   <= bitCnt + 1'b1;
              adc_sclk <= 1'b0;
              adc_din  <= txShift[15];
              txShift  <= {txShift[14:0], 1'b0};
            end
          end else begin
            halfCnt <= halfCnt + 1'b1;
          end
        end
        HOLD: begin
          if (halfCnt == H_LAST) begin
            halfCnt      <= '0;
            quietCnt     <= '0;
            state        <= QUIET;
            adc_cs_n     <= 1'b1;
            adc_din      <= 1'b0;
            sample_valid <= 1'b1;
            sample_ch    <= rxShift[14:12];
            sample_data  <= rxShift[DATA_BITS-1:0];
          end else begin
            halfCnt <= halfCnt + 1'b1;
          end
        end
        QUIET: begin
          if (quietCnt == Q_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            quietCnt <= quietCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_CH_MISMATCH_CHK_EN
  // The ADC answers each frame with data for the address sent in the
  // previous frame. The first frame after reset, or after idling with run
  // low, has no trustworthy predecessor, so it is not checked.
  logic [2:0] prevCh;
  logic       prevValid;
  logic       chErrR;
  logic       frameDone;

  assign frameDone = (state == HOLD) && (halfCnt == H_LAST);

  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      prevCh    <= '0;
      prevValid <= 1'b0;
      chErrR    <= 1'b0;
    end else if ((state == IDLE) && !run) begin
      prevValid <= 1'b0;
    end else if (frameDone) begin
      if (prevValid && (rxShift[14:12] != prevCh)) chErrR <= 1'b1;
      prevCh    <= curCh;
      prevValid <= 1'b1;
    end
  end

  assign ch_err = chErrR;
`else
  assign ch_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer at default parameters
// (H=2, Q=4 give a 73-cycle frame with cs_n low for 68 cycles).
// The ADC model captures each control word and answers every frame with
// {0, previous address, adcData}.
module tb_adc_capture_sequencer;

`ifdef ADC_CH_MISMATCH_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        CLOCK_50  = 1'b0;
  logic        resetN    = 1'b0;
  logic        run       = 1'b0;
  logic [7:0]  ch_enable = 8'h00;
  logic        adc_dout  = 1'b0;
  logic        adc_sclk, adc_cs_n, adc_din;
  logic        sample_valid;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;
  logic        busy, ch_err;

  always #10 CLOCK_50 = ~CLOCK_50;

  adc_capture_sequencer dut (
    .CLOCK_50    (CLOCK_50),
    .resetN      (resetN),
    .run         (run),
    .ch_enable   (ch_enable),
    .adc_sclk    (adc_sclk),
    .adc_cs_n    (adc_cs_n),
    .adc_din     (adc_din),
    .adc_dout    (adc_dout),
    .sample_valid(sample_valid),
    .sample_ch   (sample_ch),
    .sample_data (sample_data),
    .busy        (busy),
    .ch_err      (ch_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- ADC model ----------------
  logic [11:0] adcData      = 12'h000;
  int          badEchoFrame = -1;
  int          adcFrameNo   = 0;
  logic [2:0]  adcPrevAddr  = 3'd0;
  logic [15:0] adcTx        = 16'h0000;
  logic [15:0] adcRxCtrl    = 16'h0000;
  int          adcBit       = 0;
  logic        adcInFrame   = 1'b0;
  logic [15:0] ctrlLog[$];

  always @(negedge adc_cs_n) begin
    adcTx      = {1'b0, (adcFrameNo == badEchoFrame) ? ~adcPrevAddr : adcPrevAddr, adcData};
    adcBit     = 15;
    adcRxCtrl  = 16'h0000;
    adcInFrame = 1'b1;
  end

  always @(negedge adc_sclk) begin
    if (adcInFrame && !adc_cs_n && adcBit >= 0) begin
      adc_dout = adcTx[adcBit];
      adcBit   = adcBit - 1;
    end
  end

  always @(posedge adc_sclk) begin
    if (adcInFrame && !adc_cs_n) adcRxCtrl = {adcRxCtrl[14:0], adc_din};
  end

  always @(posedge adc_cs_n) begin
    if (adcInFrame) begin
      adcPrevAddr = adcRxCtrl[13:11];
      ctrlLog.push_back(adcRxCtrl);
      adcFrameNo++;
      adcInFrame = 1'b0;
    end
  end

  // ---------------- bus monitor (samples at negedge) ----------------
  int   ncyc = 0, fallCount = 0, riseCount = 0;
  int   lastFallCyc = 0, prevFallCyc = 0, csRiseCyc = 0;
  int   lowLen = 0, lastLowLen = 0, rises = 0, lastRises = 0;
  int   validCount = 0, lastValidCyc = 0, longValid = 0;
  int   busyFallCyc = 0, busyRiseCount = 0;
  logic prevCs = 1'b1, prevSclk = 1'b1, prevValid = 1'b0, prevBusy = 1'b0;

  always @(negedge CLOCK_50) begin
    ncyc++;
    if (prevCs && adc_cs_n === 1'b0) begin
      fallCount++;
      prevFallCyc = lastFallCyc;
      lastFallCyc = ncyc;
      lowLen = 0;
      rises  = 0;
    end
    if (adc_cs_n === 1'b0) begin
      lowLen++;
      if (!prevSclk && adc_sclk === 1'b1) rises++;
    end
    if (!prevCs && adc_cs_n === 1'b1) begin
      riseCount++;
      csRiseCyc  = ncyc;
      lastLowLen = lowLen;
      lastRises  = rises;
    end
    if (sample_valid === 1'b1) begin
      validCount++;
      lastValidCyc = ncyc;
      if (prevValid) longValid++;
    end
    if (prevBusy && busy === 1'b0) busyFallCyc = ncyc;
    if (!prevBusy && busy === 1'b1) busyRiseCount++;
    prevCs    = (adc_cs_n !== 1'b0);
    prevSclk  = (adc_sclk !== 1'b0);
    prevValid = (sample_valid === 1'b1);
    prevBusy  = (busy === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLOCK_50);
      #1;
    end
  endtask

  task automatic waitRiseCount(input int target, input string tag);
    int b = 0;
    while (riseCount < target && b < 2000) begin
      tick(1);
      b++;
    end
    check(tag, 32'(riseCount), 32'(target));
  endtask

  task automatic waitFallCount(input int target, input string tag);
    int b = 0;
    while (fallCount < target && b < 2000) begin
      tick(1);
      b++;
    end
    check(tag, 32'(fallCount), 32'(target));
  endtask

  task automatic waitBitRises(input int target, input string tag);
    int b = 0;
    while (rises < target && b < 2000) begin
      tick(1);
      b++;
    end
    check(tag, 32'(rises), 32'(target));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int vc, fc, br, rc, tgt;

    // Reset values
    tick(3);
    check("rst_sclk",  32'(adc_sclk), 32'd1);
    check("rst_cs_n",  32'(adc_cs_n), 32'd1);
    check("rst_din",   32'(adc_din), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_ch",    32'(sample_ch), 32'd0);
    check("rst_data",  32'(sample_data), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_cherr", 32'(ch_err), 32'd0);

    // Channels 0 and 2 round-robin
    adcData   = 12'h123;
    resetN    = 1'b1;
    ch_enable = 8'h05;
    run       = 1'b1;
    waitRiseCount(4, "frames_ch05");
    check("ctrl0_ch0", 32'(ctrlLog[0]), 32'h8000);
    check("ctrl1_ch2", 32'(ctrlLog[1]), 32'h9000);
    check("ctrl2_ch0", 32'(ctrlLog[2]), 32'h8000);
    check("ctrl3_ch2", 32'(ctrlLog[3]), 32'h9000);
    check("frame_period", 32'(lastFallCyc - prevFallCyc), 32'd73);
    check("cs_low_len",   32'(lastLowLen), 32'd68);
    check("sclk_rises",   32'(lastRises), 32'd16);
    check("valid_count4", 32'(validCount), 32'd4);
    check("valid_on_csrise", 32'(lastValidCyc), 32'(csRiseCyc));
    check("data_123", 32'(sample_data), 32'h123);
    check("echo_ch0", 32'(sample_ch), 32'd0);
    check("busy_in_quiet", 32'(busy), 32'd1);

    // Only channel 3: the ADC returns 0x3ABC once the previous address is 3
    ch_enable = 8'h08;
    adcData   = 12'hABC;
    waitRiseCount(7, "frames_ch3");
    check("ctrl4_ch3", 32'(ctrlLog[4]), 32'h9800);
    check("ctrl6_ch3", 32'(ctrlLog[6]), 32'h9800);
    check("sample_ch3", 32'(sample_ch), 32'd3);
    check("sample_abc", 32'(sample_data), 32'hABC);
    check("valid_on_csrise2", 32'(lastValidCyc), 32'(csRiseCyc));
    check("valid_one_cycle", 32'(longValid), 32'd0);
    tick(30);
    check("hold_valid_low", 32'(sample_valid), 32'd0);
    check("hold_ch",   32'(sample_ch), 32'd3);
    check("hold_data", 32'(sample_data), 32'hABC);

    // run dropped at bit 5: the frame finishes with its sample, then idle
    tgt = fallCount + 1;
    waitFallCount(tgt, "drop_frame_start");
    waitBitRises(5, "drop_bit5");
    run = 1'b0;
    vc  = validCount;
    fc  = fallCount;
    tgt = riseCount + 1;
    waitRiseCount(tgt, "drop_frame_end");
    check("drop_valid_once", 32'(validCount), 32'(vc + 1));
    check("drop_valid_on_csrise", 32'(lastValidCyc), 32'(csRiseCyc));
    tick(6);
    check("busy_fall_after_quiet", 32'(busyFallCyc - csRiseCyc), 32'd4);
    tick(200);
    check("idle_no_frames", 32'(fallCount), 32'(fc));
    check("idle_cs_high",   32'(adc_cs_n), 32'd1);
    check("idle_busy_low",  32'(busy), 32'd0);
    check("idle_no_valid",  32'(validCount), 32'(vc + 1));

    // Empty mask with run high: nothing happens
    ch_enable = 8'h00;
    run       = 1'b1;
    br        = busyRiseCount;
    tick(500);
    check("mask0_no_frames", 32'(fallCount), 32'(fc));
    check("mask0_no_busy",   32'(busyRiseCount), 32'(br));
    check("mask0_cs_high",   32'(adc_cs_n), 32'd1);

    // Only channel 7: repeats on 7
    ch_enable = 8'h80;
    tgt = riseCount + 2;
    waitRiseCount(tgt, "frames_ch7");
    check("ctrl_ch7_a", 32'(ctrlLog[ctrlLog.size() - 2]), 32'hB800);
    check("ctrl_ch7_b", 32'(ctrlLog[ctrlLog.size() - 1]), 32'hB800);

    // Reset mid-SHIFT during a channel-1 frame
    ch_enable = 8'h06;
    tgt = fallCount + 1;
    waitFallCount(tgt, "rst_frame_start");
    waitBitRises(4, "rst_in_shift");
    vc     = validCount;
    resetN = 1'b0;
    #2;
    check("async_cs_high",   32'(adc_cs_n), 32'd1);
    check("async_sclk_high", 32'(adc_sclk), 32'd1);
    tick(3);
    check("rst_no_valid", 32'(validCount), 32'(vc));
    check("rst_busy_low", 32'(busy), 32'd0);
    resetN = 1'b1;
    rc = riseCount;
    waitRiseCount(rc + 1, "post_rst_frame");
    check("post_rst_ctrl_ch1", 32'(ctrlLog[ctrlLog.size() - 1]), 32'h8800);
    check("post_rst_valid", 32'(validCount), 32'(vc + 1));

    // Wrong echo on the third frame after reset (channels 1, 2, 1 ...)
    badEchoFrame = adcFrameNo + 1;
    waitRiseCount(rc + 2, "frame2_after_rst");
    check("cherr_clean", 32'(ch_err), 32'd0);
    waitRiseCount(rc + 3, "frame3_after_rst");
    check("bad_echo_ch", 32'(sample_ch), 32'd5);
    check("cherr_on_bad", 32'(ch_err), 32'(EXP_ERR));
    waitRiseCount(rc + 5, "frames_after_bad");
    check("cherr_sticky", 32'(ch_err), 32'(EXP_ERR));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
- Sequences serial conversion frames to the 8-channel, 12-bit ADC behind the signal capture block.
- Generates adc_sclk internally from CLOCK_50 by cycle counting, so it supersedes the free-running SCLK divider.
- Round-robins over enabled channels, drives CS/MOSI, captures MISO.
- Presents each sample with its channel tag as a one-cycle valid pulse to downstream capture logic.

Parameters:
- SCLK_HALF, 2, CLOCK_50 cycles per adc_sclk half-period (H); legal range ≥1.
- QUIET_CYCLES, 4, cs_n-high cycles between frames (Q); legal range ≥1.
- NUM_CH, 8, channel count; fixed at 8, 3-bit address.
- DATA_BITS, 12, sample width.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetN  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = continuous conversion.
- ch_enable  in  8  channel mask; bit i enables channel i.
- adc_sclk  out  1  serial clock to ADC; idles high.
- adc_cs_n  out  1  chip select, active low.
- adc_din  out  1  MOSI, control word to ADC.
- adc_dout  in  1  MISO from ADC.
- sample_valid  out  1  one-cycle pulse per completed frame.
- sample_ch  out  3  channel ID echoed in the frame.
- sample_data  out  12  conversion result.
- busy  out  1  high from cs_n fall through end of QUIET.
- ch_err  out  1  sticky channel-mismatch flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset resetN is asynchronous, active-low. All outputs are registered.
- Reset values: adc_sclk=1, adc_cs_n=1, adc_din=0, sample_valid=0, sample_ch=0, sample_data=0, busy=0, ch_err=0, state=IDLE, cur_ch=7.
- Reset asserted mid-frame: cs_n and sclk go high immediately. The partial frame is discarded and no sample_valid is issued.
- FSM states: IDLE → SETUP → SHIFT → HOLD → QUIET → IDLE.
- IDLE:
  - If run=1 and ch_enable≠0, select next_ch and go to SETUP; else stay.
  - next_ch is the lowest enabled index strictly greater than cur_ch, wrapping to the lowest enabled index.
  - A single enabled channel repeats.
  - After reset, the first pick is the lowest enabled index.
- SETUP (H cycles): cs_n=0, sclk=1, adc_din=ctrl[15].
- Control word: ctrl = {1'b1, 1'b0, next_ch[2:0], 11'b0}, shifted MSB first.
- SHIFT (32H cycles), 16 bits, each bit is H cycles sclk=0 then H cycles sclk=1:
  - adc_din updates on the cycle sclk falls.
  - adc_dout is sampled into the shift register on the cycle sclk rises.
- Received frame bit order: bit15 = don't-care, bits14:12 = channel echo, bits11:0 = data MSB first.
- HOLD (H cycles): cs_n=0, sclk=1.
- QUIET (Q cycles): cs_n=1.
  - First QUIET cycle: sample_valid=1; sample_ch and sample_data load from the frame and hold until the next pulse.
- Frame period: 1 + 34H + Q cycles (73 at defaults). cs_n is low for exactly 34H cycles.
- run deasserted mid-frame: the current frame completes, including sample_valid, then the FSM idles.
- ch_enable sampled only in IDLE: changes mid-frame affect the next selection only.
- ch_enable=0 with run=1: stays in IDLE, busy=0, outputs static.
- Counters: bit counter 0..15, half-period counter 0..H-1; no overflow paths.

Optional Feature:
- Macro: ADC_CH_MISMATCH_CHK_EN.
- With the macro defined:
  - Track the channel addressed in the previous frame (the ADC returns data for the prior address).
  - On each frame's sample_valid, compare the echo with that channel. Any mismatch sets ch_err=1, sticky until reset.
  - The first frame after reset or after IDLE with run=0 is exempt.
- Without the macro: ch_err is tied 0 and no comparison logic exists.

Test Plan:
- Defaults, ch_enable=8'h05, run=1 → cs_n falls on channels 0, 2, 0, 2…, frames 73 cycles apart. Captured ctrl bits 13:11 are 000, 010, 000. Each frame has 16 sclk rising edges with cs_n low for 68 cycles.
- ADC model returns frame 0x3ABC → one-cycle sample_valid on the first cs_n-high cycle with sample_ch=3, sample_data=12'hABC. Values are held until the next pulse.
- run dropped at bit 5 of a frame → frame completes, one sample_valid follows, then cs_n stays high and busy falls after 4 QUIET cycles.
- ch_enable=0, run=1 → no cs_n activity for 500 cycles. Setting ch_enable=8'h80 → next frame addresses channel 7 and repeats on channel 7.
- resetN pulsed low mid-SHIFT → cs_n=1, sclk=1 asynchronously, no sample_valid. After release the first frame addresses the lowest enabled channel.
- With ADC_CH_MISMATCH_CHK_EN: model echoes a wrong channel on frame 3 → ch_err rises with frame 3's sample_valid and stays 1. Without the macro, ch_err stays 0.
